// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_IT  = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   dq_q;      // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [W-1:0]   dvs_q;     // divisor magnitude
  logic [W-1:0]   rem_q;     // partial remainder (always below the divisor, so W bits suffice)
  logic           rem_sel_q; // 1: REM/REMU, 0: DIV/DIVU
  logic           neg_q_q;
  logic           neg_r_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   result_q;

  logic           is_signed;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           div_zero;
  logic           ovf;
  logic [W-1:0]   special_res;

  logic [W:0]     rem_shift;
  logic [W:0]     diff;
  logic           take;
  logic [W-1:0]   rem_nx;
  logic [W-1:0]   dq_nx;
  logic [W-1:0]   final_res;

  // Operand preparation from the raw request inputs, used only when a start is accepted
  always_comb begin
    is_signed   = ~div_op[0];
    a_neg       = is_signed & op1[W-1];
    b_neg       = is_signed & op2[W-1];
    abs_a       = a_neg ? -op1 : op1;
    abs_b       = b_neg ? -op2 : op2;
    div_zero    = (op2 == '0);
    ovf         = is_signed && (op1 == MIN_NEG) && (op2 == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = div_op[1] ? op1 : '1;
    end else if (ovf) begin
      special_res = div_op[1] ? '0 : MIN_NEG;
    end
  end

  // One restoring shift-subtract step plus sign fix-up of the value it would finish with
  always_comb begin
    rem_shift = {rem_q, dq_q[W-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    take      = ~diff[W];
    rem_nx    = take ? diff[W-1:0] : rem_shift[W-1:0];
    dq_nx     = {dq_q[W-2:0], take};
    if (rem_sel_q) begin
      final_res = neg_r_q ? -rem_nx : rem_nx;
    end else begin
      final_res = neg_q_q ? -dq_nx : dq_nx;
    end
  end

  // Control FSM with registered busy/done/result; reset beats flush, flush beats start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            rem_sel_q <= div_op[1];
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            dq_q      <= abs_a;
            dvs_q     <= abs_b;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (div_zero || ovf) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          dq_q  <= dq_nx;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_IT) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= final_res;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  div_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .div_op (div_op),
    .op1    (op1),
    .op2    (op2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain language arithmetic with the RISC-V divide-by-zero rule
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      return op[1] ? (a % b) : (a / b);
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one request from IDLE, measure cycles from the start edge to done
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat);
    @(negedge clk);
    start = 1'b1; div_op = op; op1 = a; op2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    check({tag, "_busy_first"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 100; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    res = result;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_release"}, 32'(busy), 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int n, output logic [31:0] last);
    n = 0;
    last = result;
    for (int i = 0; i < cycles; i++) begin
      if (done) begin
        n++;
        last = result;
      end
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; div_op = op; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] res, last, ra, rb;
    logic [1:0]  rop;
    int          lat, n, sel;

    vecs[0]  = '{OP_DIV,  32'd100,       32'd7,         32'd14,        33};
    vecs[1]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33};
    vecs[2]  = '{OP_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         33};
    vecs[3]  = '{OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33};
    vecs[4]  = '{OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33};
    vecs[5]  = '{OP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         33};
    vecs[6]  = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        33};
    vecs[7]  = '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{OP_REMU, 32'd5,         32'd0,         32'd5,         1};
    vecs[9]  = '{OP_DIV,  32'hFFFF_FFFD, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[10] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; div_op = 2'b00; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_result", result,    32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // start while busy is ignored
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    launch(OP_DIV, 32'd9, 32'd3);
    count_dones(80, n, last);
    check("busy_rej_done_count", 32'(n), 32'd1);
    check("busy_rej_result", last, 32'd14);

    // flush mid-CALC
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    count_dones(50, n, last);
    check("flush_no_done", 32'(n), 32'd0);
    check("flush_result_held", result, 32'd14);
    run_op("post_flush", OP_DIVU, 32'd9, 32'd3, res, lat);
    check("post_flush_result", res, 32'd3);
    check("post_flush_latency", 32'(lat), 32'd33);

    // reset mid-CALC
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_done",   32'(done), 32'd0);
    check("midrst_result", result,    32'd0);
    count_dones(50, n, last);
    check("midrst_no_done", 32'(n), 32'd0);
    run_op("post_rst", OP_REM, 32'd10, 32'd3, res, lat);
    check("post_rst_result", res, 32'd1);

    // randomized requests against the reference model
    for (int k = 0; k < 120; k++) begin
      rop = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
        3: rb = rb >> $urandom_range(0, 31);
        4: ra = ra >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", k), rop, ra, rb, res, lat);
      check($sformatf("rnd%0d_op%0d_%08h_%08h", k, rop, ra, rb), res, ref_div(rop, ra, rb));
      check($sformatf("rnd%0d_latency", k), 32'(lat), 32'(ref_lat(rop, ra, rb)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
